// File: rtl/gx_fifo_fetch.sv
// ---------------------------------------------------------------------------
// gx_fifo_fetch
//   AXI4 read-burst master that streams GX command-FIFO data out of a memory
//   ring buffer. Bursts are fetched into a local beat buffer and handed to the
//   command processor as OUT_W-bit words, least-significant word first.
//
// Ports
//   clk, reset         : single clock, asynchronous active-high reset
//   enable             : allow new bursts to be issued
//   cfg_base/cfg_end   : ring bounds (end exclusive), BURST_BYTES aligned
//   cfg_wrptr          : producer write pointer
//   rdptr, load_rdptr  : consumer read pointer; load_rdptr reloads it from
//                        cfg_base while idle
//   ar*/r*             : AXI4 read address / read data channels
//   gx_valid/gx_data   : output word available / current word
//   gx_read            : consume the current word
//   bus_err            : sticky flag, set by any non-OKAY read response
//   busy               : a burst is in flight
//
// Optional build macro GX_FETCH_STATS_EN adds beat_count and burst_count.
// ---------------------------------------------------------------------------
module gx_fifo_fetch #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int OUT_W      = 32,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_end,
  input  logic [ADDR_W-1:0] cfg_wrptr,
  output logic [ADDR_W-1:0] rdptr,
  input  logic              load_rdptr,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              gx_valid,
  output logic [OUT_W-1:0]  gx_data,
  input  logic              gx_read,
  output logic              bus_err,
`ifdef GX_FETCH_STATS_EN
  output logic [31:0]       beat_count,
  output logic [31:0]       burst_count,
`endif
  output logic              busy
);

  localparam int WORDS       = DATA_W / OUT_W;
  localparam int IDX_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_BYTES);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   rdptr_q,   rdptr_d;
  logic [ADDR_W-1:0]   araddr_q,  araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q,  rready_d;
  logic                busy_q,    busy_d;
  logic                bus_err_q, bus_err_d;
  logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]    count_q,   count_d;
  logic [IDX_W-1:0]    word_idx_q, word_idx_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                push_s;
  logic                pop_word_s;
  logic                pop_s;
  logic                gx_valid_s;
  logic                start_s;
  logic [CNT_W-1:0]    free_s;
  logic [ADDR_W-1:0]   rdptr_inc_s;
  logic [WORDS-1:0][OUT_W-1:0] head_words_s;

  assign gx_valid_s   = (count_q != {CNT_W{1'b0}});
  assign push_s       = (state_q == ST_DATA) && rready_q && rvalid;
  assign pop_word_s   = gx_read && gx_valid_s;
  assign pop_s        = pop_word_s && (word_idx_q == LAST_IDX);
  assign free_s       = DEPTH_C - count_q;
  assign rdptr_inc_s  = rdptr_q + BURST_INC;
  // A burst is only started when the whole burst fits, so R never stalls.
  assign start_s      = enable && (rdptr_q != cfg_wrptr) && (free_s >= BURST_C) && !load_rdptr;
  assign head_words_s = mem_q[rd_ptr_q];

  // Burst FSM next-state and AXI/pointer register inputs.
  always_comb begin
    state_d   = state_q;
    rdptr_d   = rdptr_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    case (state_q)
      ST_IDLE: begin
        if (load_rdptr) begin
          rdptr_d = cfg_base;
        end else if (start_s) begin
          araddr_d  = rdptr_q;
          arvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rvalid && rlast) begin
          rready_d = 1'b0;
          state_d  = ST_IDLE;
          rdptr_d  = (rdptr_inc_s == cfg_end) ? cfg_base : rdptr_inc_s;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Beat buffer pointers, occupancy, output word index and error flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    bus_err_d  = bus_err_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pop_word_s) begin
      word_idx_d = pop_s ? {IDX_W{1'b0}} : (word_idx_q + IDX_W'(1));
    end else begin
      word_idx_d = word_idx_q;
    end
    // Errored beats are still stored; only the sticky flag records them.
    if (push_s && (rresp != 2'b00)) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rdptr_q    <= {ADDR_W{1'b0}};
      araddr_q   <= {ADDR_W{1'b0}};
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      busy_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      word_idx_q <= {IDX_W{1'b0}};
    end else begin
      state_q    <= state_d;
      rdptr_q    <= rdptr_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      busy_q     <= busy_d;
      bus_err_q  <= bus_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Beat storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rdata;
    end
  end

`ifdef GX_FETCH_STATS_EN
  logic [31:0] beat_count_q,  beat_count_d;
  logic [31:0] burst_count_q, burst_count_d;

  // Free-running statistics counters, wrapping at 2^32.
  always_comb begin
    beat_count_d  = beat_count_q;
    burst_count_d = burst_count_q;
    if (push_s) begin
      beat_count_d = beat_count_q + 32'd1;
      if (rlast) begin
        burst_count_d = burst_count_q + 32'd1;
      end else begin
        burst_count_d = burst_count_q;
      end
    end else begin
      beat_count_d = beat_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count_q  <= 32'd0;
      burst_count_q <= 32'd0;
    end else begin
      beat_count_q  <= beat_count_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign burst_count = burst_count_q;
`endif

  assign rdptr    = rdptr_q;
  assign araddr   = araddr_q;
  assign arvalid  = arvalid_q;
  assign rready   = rready_q;
  assign busy     = busy_q;
  assign bus_err  = bus_err_q;
  assign arlen    = 4'(BURST_LEN - 1);
  assign arsize   = 3'($clog2(DATA_W / 8));
  assign arburst  = 2'b01;
  assign gx_valid = gx_valid_s;
  // Combinational slice of the head beat; forced to zero while empty.
  assign gx_data  = gx_valid_s ? head_words_s[word_idx_q] : {OUT_W{1'b0}};

endmodule
